// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
// Used by ram_arbiter, rr_pick2 and ram_arbiter_if.
package ram_arb_pkg;

  localparam int RAM_ADDR_W  = 5;
  localparam int RAM_DATA_W  = 32;
  localparam int GRANT_CNT_W = 16;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2
  } arb_state_t;

  // Both requesting: the one that did not win last time.
  function automatic logic rr_winner(input logic req0, input logic req1,
                                     input logic last_grant);
    logic w;
    w = M0;
    if (req0 && req1) begin
      w = ~last_grant;
    end else if (req1) begin
      w = M1;
    end
    return w;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester and RAM-side bus of the RAM arbiter; slave = arbiter, master = environment.
// Grant counters exist only when RAM_ARB_STATS_EN is defined.
interface ram_arbiter_if import ram_arb_pkg::*; #(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
`ifdef RAM_ARB_STATS_EN
  , parameter int CNT_W = GRANT_CNT_W
`endif
) ();

  logic              m0_req;
  logic              m0_wr;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_ack;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_wr;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_ack;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic              ram_cen;
  logic              ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

`ifdef RAM_ARB_STATS_EN
  logic [CNT_W-1:0]  m0_grant_cnt;
  logic [CNT_W-1:0]  m1_grant_cnt;
`endif

  modport slave (
    input  m0_req, m0_wr, m0_addr, m0_wdata,
    input  m1_req, m1_wr, m1_addr, m1_wdata,
    input  ram_dout,
    output m0_ack, m0_rvalid, m0_rdata,
    output m1_ack, m1_rvalid, m1_rdata,
    output ram_cen, ram_wen, ram_addr, ram_din
`ifdef RAM_ARB_STATS_EN
    , output m0_grant_cnt, m1_grant_cnt
`endif
  );

  modport master (
    output m0_req, m0_wr, m0_addr, m0_wdata,
    output m1_req, m1_wr, m1_addr, m1_wdata,
    output ram_dout,
    input  m0_ack, m0_rvalid, m0_rdata,
    input  m1_ack, m1_rvalid, m1_rdata,
    input  ram_cen, ram_wen, ram_addr, ram_din
`ifdef RAM_ARB_STATS_EN
    , input m0_grant_cnt, m1_grant_cnt
`endif
  );

endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin select: a lone requester wins,
// a tie goes to the requester that was not granted last.
module rr_pick2 import ram_arb_pkg::*; (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid  = req0 | req1;
    winner = rr_winner(req0, req1, last_grant);
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbiter/sequencer sharing one single-port registered-output RAM between two requesters.
// Define RAM_ARB_STATS_EN to add saturating per-requester grant counters.
module ram_arbiter import ram_arb_pkg::*; #(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
`ifdef RAM_ARB_STATS_EN
  , parameter int CNT_W = GRANT_CNT_W
`endif
) (
  input logic          clk,
  input logic          reset,
  ram_arbiter_if.slave bus
);

  arb_state_t state;
  arb_state_t state_next;

  logic              last_grant;
  logic              winner_q;
  logic              wr_q;
  logic              pick_valid;
  logic              pick_winner;
  logic              grant;

  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              ram_cen_q;
  logic              ram_wen_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_din_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  logic              ack0;
  logic              ack1;
  logic              rvalid0;
  logic              rvalid1;

  rr_pick2 u_pick (
    .req0       (bus.m0_req),
    .req1       (bus.m1_req),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  always_comb begin
    sel_wr    = bus.m0_wr;
    sel_addr  = bus.m0_addr;
    sel_wdata = bus.m0_wdata;
    if (pick_winner == M1) begin
      sel_wr    = bus.m1_wr;
      sel_addr  = bus.m1_addr;
      sel_wdata = bus.m1_wdata;
    end
  end

  // New grants are only taken from IDLE, so cen can never be high two cycles running.
  assign grant = (state == IDLE) && pick_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ack0       = 1'b0;
    ack1       = 1'b0;
    rvalid0    = 1'b0;
    rvalid1    = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        ack0       = (winner_q == M0);
        ack1       = (winner_q == M1);
        state_next = wr_q ? IDLE : RDATA;
      end
      RDATA: begin
        rvalid0    = (winner_q == M0);
        rvalid1    = (winner_q == M1);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // RAM controls are registered at the grant edge and dropped one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= M1;
      winner_q   <= M0;
      wr_q       <= 1'b0;
      ram_cen_q  <= 1'b0;
      ram_wen_q  <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      ram_cen_q <= 1'b0;
      ram_wen_q <= 1'b0;
      if (grant) begin
        winner_q   <= pick_winner;
        wr_q       <= sel_wr;
        last_grant <= pick_winner;
        ram_cen_q  <= 1'b1;
        ram_wen_q  <= sel_wr;
        ram_addr_q <= sel_addr;
        ram_din_q  <= sel_wdata;
      end
      if (rvalid0) begin
        rdata0_q <= bus.ram_dout;
      end
      if (rvalid1) begin
        rdata1_q <= bus.ram_dout;
      end
    end
  end

  // The RAM output is already registered, so the winner sees it in the RDATA cycle itself.
  assign bus.m0_rdata  = rvalid0 ? bus.ram_dout : rdata0_q;
  assign bus.m1_rdata  = rvalid1 ? bus.ram_dout : rdata1_q;
  assign bus.m0_ack    = ack0;
  assign bus.m1_ack    = ack1;
  assign bus.m0_rvalid = rvalid0;
  assign bus.m1_rvalid = rvalid1;
  assign bus.ram_cen   = ram_cen_q;
  assign bus.ram_wen   = ram_wen_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_din   = ram_din_q;

`ifdef RAM_ARB_STATS_EN
  logic [CNT_W-1:0] m0_cnt;
  logic [CNT_W-1:0] m1_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      m0_cnt <= '0;
      m1_cnt <= '0;
    end else begin
      if (ack0 && (m0_cnt != {CNT_W{1'b1}})) begin
        m0_cnt <= m0_cnt + 1'b1;
      end
      if (ack1 && (m1_cnt != {CNT_W{1'b1}})) begin
        m1_cnt <= m1_cnt + 1'b1;
      end
    end
  end

  assign bus.m0_grant_cnt = m0_cnt;
  assign bus.m1_grant_cnt = m1_cnt;
`endif

endmodule
